// File: rtl/cordic_pkg.sv
// cordic_pkg: constants, state encoding and iteration count shared by the CORDIC cores
package cordic_pkg;
    localparam logic [15:0] PI_HALF_DEF = 16'h6488;
    localparam logic [15:0] CORDIC_INV_GAIN = 16'h26dd;
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
    function automatic int iter_count(input int data_width);
        return data_width - 1;
    endfunction
endpackage

// File: rtl/cordic_prerot.sv
// cordic_prerot: folds the input vector into the right half-plane and flags the all-zero vector
module cordic_prerot
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PI_HALF = PI_HALF_DEF
) (
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    output logic signed [DATA_WIDTH+2:0] x0,
    output logic signed [DATA_WIDTH+2:0] y0,
    output logic signed [DATA_WIDTH+2:0] z0,
    output logic zero
);
    localparam int W = DATA_WIDTH + 3;
    logic signed [W-1:0] xs, ys, zp;
    always_comb begin
        xs = W'(x_in);
        ys = W'(y_in);
        zp = {3'b000, PI_HALF};
        x0 = x_in[DATA_WIDTH-1] ? (y_in[DATA_WIDTH-1] ? -ys : ys) : xs;
        y0 = x_in[DATA_WIDTH-1] ? (y_in[DATA_WIDTH-1] ? xs : -xs) : ys;
        z0 = x_in[DATA_WIDTH-1] ? (y_in[DATA_WIDTH-1] ? -zp : zp) : '0;
        zero = ~|{x_in, y_in};
    end
endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC returning atan2(y, x) and the gain-scaled magnitude
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] PI_HALF = PI_HALF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    input  logic signed [DATA_WIDTH-1:0] q,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic busy,
    output logic done,
    output logic [DATA_WIDTH+1:0] mag,
    output logic signed [DATA_WIDTH:0] ang
);
    localparam int W = DATA_WIDTH + 3;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(iter_count(DATA_WIDTH) - 1);
    state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [W-1:0] x0, y0, z0, x_sh, y_sh, q_ext, x_it, y_it, z_it;
    logic [DATA_WIDTH+1:0] mag_q, mag_d;
    logic signed [DATA_WIDTH:0] ang_q, ang_d;
    logic zero_q, zero_d, zero0, done_q, done_d, neg;

    cordic_prerot #(.DATA_WIDTH(DATA_WIDTH), .PI_HALF(PI_HALF)) u_prerot (
        .x_in(x_in),
        .y_in(y_in),
        .x0(x0),
        .y0(y0),
        .z0(z0),
        .zero(zero0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q <= '0;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            zero_q <= 1'b0;
            mag_q <= '0;
            ang_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            zero_q <= zero_d;
            mag_q <= mag_d;
            ang_q <= ang_d;
            done_q <= done_d;
        end
    end

    // y sign picks the rotation that drives y toward zero
    always_comb begin
        x_sh = x_q >>> n_q;
        y_sh = y_q >>> n_q;
        q_ext = W'(q);
        neg = y_q[W-1];
        x_it = neg ? x_q - y_sh : x_q + y_sh;
        y_it = neg ? y_q + x_sh : y_q - x_sh;
        z_it = neg ? z_q - q_ext : z_q + q_ext;
        state_d = state_q;
        n_d = n_q;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        zero_d = zero_q;
        mag_d = mag_q;
        ang_d = ang_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                state_d = ITER;
                n_d = '0;
                x_d = x0;
                y_d = y0;
                z_d = z0;
                zero_d = zero0;
            end
            ITER: begin
                x_d = x_it;
                y_d = y_it;
                z_d = z_it;
                state_d = (n_q == LAST) ? DONE : ITER;
                n_d = (n_q == LAST) ? '0 : n_q + 1'b1;
            end
            DONE: begin
                mag_d = zero_q ? '0 : x_q[DATA_WIDTH+1:0];
                ang_d = zero_q ? '0 : z_q[DATA_WIDTH:0];
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr = n_q;
        busy = state_q != IDLE;
        done = done_q;
        mag = mag_q;
        ang = ang_q;
    end
endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: directed vectors plus a real-arithmetic atan2/magnitude model checked every cycle
module tb_cordic_vector;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic signed [DW-1:0] y_in = '0;
    logic signed [DW-1:0] q;
    logic [3:0] addr;
    logic busy, done;
    logic [DW+1:0] mag;
    logic signed [DW:0] ang;
    int rom [16];
    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    int cyc = 0, last_e = -1, st = -1;
    int p_mag = 0, p_ang = 0, p_tm = 0, p_ta = 0;
    int h_mag = 0, h_ang = 0, h_tm = 0, h_ta = 0;
    bit b_exp, d_exp;

    always #5 clk = ~clk;
    assign q = DW'(rom[addr]);

    cordic_vector dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .x_in(x_in),
        .y_in(y_in),
        .q(q),
        .addr(addr),
        .busy(busy),
        .done(done),
        .mag(mag),
        .ang(ang)
    );

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    function automatic int exp_mag(input int x, input int y);
        real g = 1.0;
        if (x == 0 && y == 0) return 0;
        for (int i = 0; i < DW - 1; i++) g = g * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        return int'($sqrt(real'(x) * x + real'(y) * y) * g);
    endfunction

    function automatic int exp_ang(input int x, input int y);
        if (x == 0 && y == 0) return 0;
        return int'($atan2(real'(y), real'(x)) * 16384.0);
    endfunction

    // Model: one operation per 17 edges, result lands 16 edges after the accepting edge
    always @(posedge clk) begin
        last_e <= cyc;
        cyc <= cyc + 1;
        if (rst) begin
            st <= -1;
            h_mag <= 0;
            h_ang <= 0;
            h_tm <= 0;
            h_ta <= 0;
        end else begin
            if (st >= 0 && cyc == st + 16) begin
                h_mag <= p_mag;
                h_ang <= p_ang;
                h_tm <= p_tm;
                h_ta <= p_ta;
            end
            if (en && (st < 0 || cyc >= st + 17)) begin
                st <= cyc;
                p_mag <= exp_mag(int'(x_in), int'(y_in));
                p_ang <= exp_ang(int'(x_in), int'(y_in));
                p_tm <= (x_in == 0 && y_in == 0) ? 0 : 16;
                p_ta <= (x_in == 0 && y_in == 0) ? 0 : 8;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            b_exp = st >= 0 && last_e >= st && last_e <= st + 15;
            d_exp = st >= 0 && last_e == st + 16;
            check("busy", int'(busy), int'(b_exp), 0);
            check("done", int'(done), int'(d_exp), 0);
            if (!b_exp) check("addr_idle", int'(addr), 0, 0);
            else if (last_e - st <= 14) check("addr_iter", int'(addr), last_e - st, 0);
            check("mag_model", int'(mag), h_mag, h_tm);
            check("ang_model", int'(ang), h_ang, h_ta);
        end
    end

    task automatic start(input int xi, input int yi);
        @(negedge clk);
        x_in = DW'(xi);
        y_in = DW'(yi);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        bcnt = int'(busy);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done) bcnt += int'(busy);
        end
    endtask

    task automatic run_vec(input string name, input int xi, input int yi,
                           input int m_lit, input int m_tol, input int a_lit, input int a_tol);
        int lat, bcnt;
        start(xi, yi);
        wait_done(lat, bcnt);
        check({name, " latency"}, lat, 16, 0);
        check({name, " busy_cycles"}, bcnt, 16, 0);
        check({name, " mag"}, int'(mag), m_lit, m_tol);
        check({name, " ang"}, int'(ang), a_lit, a_tol);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, nd, t_prev, guard;
        for (int i = 0; i < 16; i++) rom[i] = int'($atan($pow(2.0, -1.0 * i)) * 16384.0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", int'(busy), 0, 0);
        check("reset done", int'(done), 0, 0);
        check("reset mag", int'(mag), 0, 0);
        check("reset ang", int'(ang), 0, 0);
        check("reset addr", int'(addr), 0, 0);
        armed = 1'b1;
        run_vec("x_axis", 16'h4000, 0, 26981, 8, 0, 8);
        run_vec("diag", 16'h2000, 16'h2000, 19079, 8, 12868, 8);
        run_vec("pos_y", 0, 16'h4000, 26981, 16, 25736, 8);
        run_vec("neg_x", -16'h4000, 0, 26981, 16, 51472, 8);
        run_vec("neg_y", 0, -16'h4000, 26981, 16, -25736, 8);
        run_vec("min_min", -32768, -32768, 76316, 16, -38604, 8);
        run_vec("zero", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        x_in = 16'sh3000;
        y_in = -16'sh1000;
        en = 1'b1;
        nd = 0;
        t_prev = -1;
        guard = 0;
        while (nd < 4 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
            if (done) begin
                if (t_prev >= 0) check("held_en period", guard - t_prev, 17, 0);
                t_prev = guard;
                nd++;
            end
        end
        check("held_en pulses", nd, 4, 0);
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(posedge clk);
        start(16'h4000, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        x_in = 0;
        y_in = 16'sh4000;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done(lat, bcnt);
        check("ignore latency", lat, 10, 0);
        check("ignore mag", int'(mag), 26981, 8);
        check("ignore ang", int'(ang), 0, 8);
        repeat (20) @(posedge clk);
        start(16'h2000, 16'h2000);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abort addr", int'(addr), 7, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", int'(busy), 0, 0);
        check("abort mag", int'(mag), 0, 0);
        check("abort ang", int'(ang), 0, 0);
        check("abort addr_after", int'(addr), 0, 0);
        check("abort done", int'(done), 0, 0);
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            nd += int'(done);
        end
        check("abort no_done", nd, 0, 0);
        run_vec("after_abort", 16'h2000, 16'h2000, 19079, 8, 12868, 8);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
